// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets as decoded from addr[3:2]
//   - STATUS register bit positions
//   - transmit FSM state encoding
//   - helper that maps a programmed baud divisor to an effective one
// ---------------------------------------------------------------------------
package uart_pkg;

    // Word offsets within the block (value of addr[3:2])
    localparam logic [1:0] TXDATA_OFS  = 2'd0;
    localparam logic [1:0] STATUS_OFS  = 2'd1;
    localparam logic [1:0] BAUDDIV_OFS = 2'd2;
    localparam logic [1:0] RSVD_OFS    = 2'd3;

    // STATUS register bit positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_FULL_BIT = 1;
    localparam int STATUS_OVR_BIT  = 2;
    localparam int STATUS_WIDTH    = 3;

    // Transmit FSM encoding
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // A divisor of zero would give a zero-length bit; run it as one clock.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio_if
// Core data-side access bundle toward the UART peripheral.
//   sel   : peripheral select (core access targets this block)
//   we    : write strobe; a write happens only on sel & we
//   addr  : byte offset, only [3:2] decoded
//   wdata : store data
//   rdata : combinational load data, zero when not selected
// master = core side, slave = peripheral side.
// ---------------------------------------------------------------------------
interface uart_tx_mmio_if;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output sel,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/uart_tx_shifter.sv
// ---------------------------------------------------------------------------
// uart_tx_shifter
// 8N1 serialiser: transmit FSM, baud counter, data bit index and shift
// register. Takes a byte from the register file through a load/ready
// handshake and drives the serial line from a flop.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load        : take load_data this cycle (only honoured while ready)
//   load_data   : byte to transmit
//   div         : programmed baud divisor (clocks per bit), latched per frame
//   ready       : shifter can accept a byte this cycle
//   busy        : a frame is in progress
//   tx          : serial output, idles high
// ---------------------------------------------------------------------------
module uart_tx_shifter
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  load_data,
    input  logic [15:0] div,
    output logic        ready,
    output logic        busy,
    output logic        tx
);

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;          // clocks left in current bit, minus one
    logic [15:0] div_lat_q, div_lat_d;  // divisor frozen for this frame
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;

    logic        bit_end;
    logic [15:0] div_eff;

    assign div_eff = eff_div(div);
    assign bit_end = (cnt_q == 16'd0);

    // Ready on the last clock of the stop bit as well as in idle, so a
    // waiting byte starts immediately after the stop bit with no gap.
    assign ready = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
    assign busy  = (state_q != TX_IDLE);
    assign tx    = tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            cnt_q     <= 16'd0;
            div_lat_q <= 16'd0;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_lat_q <= div_lat_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    // tx_d is the line level for the bit that begins at the next edge, so
    // the registered tx changes exactly on bit boundaries.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_lat_d = div_lat_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;

        if (!bit_end) begin
            cnt_d = cnt_q - 16'd1;
        end

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    state_d   = TX_START;
                    shift_d   = load_data;
                    div_lat_d = div_eff;
                    cnt_d     = div_eff - 16'd1;
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b0;
                end
            end

            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = div_lat_q - 16'd1;
                    tx_d      = shift_q[0];
                end
            end

            TX_DATA: begin
                if (bit_end) begin
                    cnt_d = div_lat_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // shift_q[0] is always the bit on the line
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end

            TX_STOP: begin
                if (bit_end) begin
                    if (load) begin
                        state_d   = TX_START;
                        shift_d   = load_data;
                        div_lat_d = div_eff;
                        cnt_d     = div_eff - 16'd1;
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
// Memory-mapped UART transmitter. Stores load a one-entry hold register,
// the shifter drains it and sends 8N1 on tx. Loads return TXDATA, STATUS
// and BAUDDIV combinationally so a load word completes in its own cycle.
// Parameters:
//   DIV_RESET : baud divisor after reset (clocks per bit)
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : core data access (sel/we/addr/wdata in, rdata out)
//   tx        : serial line, idles high
// Register map (addr[3:2]):
//   0 TXDATA  W: hold <= wdata[7:0]   R: {24'b0, hold}
//   1 STATUS  R: {29'b0, overrun, hold_full, busy}  W: bit2=1 clears overrun
//   2 BAUDDIV R/W bits [15:0]
//   3 reserved, reads 0
// ---------------------------------------------------------------------------
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd434
)
(
    input  logic           clk,
    input  logic           rst,
    uart_tx_mmio_if.slave  bus,
    output logic           tx
);

    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        overrun_q, overrun_d;
    logic [15:0] baud_div_q, baud_div_d;

    logic [1:0]  reg_ofs;
    logic        wr_en;
    logic        txdata_wr;
    logic        status_wr;
    logic        baud_wr;

    logic        sh_load;
    logic        sh_ready;
    logic        sh_busy;

    logic [STATUS_WIDTH-1:0] status_vec;

    // Byte-lane bits and the upper store data are not decoded by this block.
    logic        unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata[31:16]};

    assign reg_ofs   = bus.addr[3:2];
    assign wr_en     = bus.sel & bus.we;
    assign txdata_wr = wr_en && (reg_ofs == TXDATA_OFS);
    assign status_wr = wr_en && (reg_ofs == STATUS_OFS);
    assign baud_wr   = wr_en && (reg_ofs == BAUDDIV_OFS);

    // Hold drains whenever it has a byte and the shifter can take one.
    assign sh_load = hold_full_q & sh_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            baud_div_q  <= DIV_RESET;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            overrun_q   <= overrun_d;
            baud_div_q  <= baud_div_d;
        end
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;
        baud_div_d  = baud_div_q;

        if (sh_load) begin
            hold_full_d = 1'b0;
        end

        // A write that lands in the same cycle the hold drains refills it;
        // only a write into a full, non-draining hold is dropped.
        if (txdata_wr) begin
            if (!hold_full_q || sh_load) begin
                hold_d      = bus.wdata[7:0];
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (status_wr && bus.wdata[STATUS_OVR_BIT]) begin
            overrun_d = 1'b0;
        end

        if (baud_wr) begin
            baud_div_d = bus.wdata[15:0];
        end
    end

    always_comb begin
        status_vec                  = '0;
        status_vec[STATUS_BUSY_BIT] = sh_busy;
        status_vec[STATUS_FULL_BIT] = hold_full_q;
        status_vec[STATUS_OVR_BIT]  = overrun_q;
    end

    // Read mux is purely combinational so the load completes this cycle.
    always_comb begin
        bus.rdata = 32'd0;
        if (bus.sel) begin
            case (reg_ofs)
                TXDATA_OFS:  bus.rdata = {24'd0, hold_q};
                STATUS_OFS:  bus.rdata = {{(32-STATUS_WIDTH){1'b0}}, status_vec};
                BAUDDIV_OFS: bus.rdata = {16'd0, baud_div_q};
                default:     bus.rdata = 32'd0;
            endcase
        end
    end

    uart_tx_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (hold_q),
        .div       (baud_div_q),
        .ready     (sh_ready),
        .busy      (sh_busy),
        .tx        (tx)
    );

endmodule
